// File: rtl/odd_result_pipe_pkg.sv
// Shared types, field positions and helpers for the odd-pipe result pipeline.
// Optional statistics are enabled with the ODD_RESULT_PIPE_STATS_EN macro.
package odd_result_pipe_pkg;

    localparam int unsigned DEPTH       = 7;
    localparam int unsigned FLUSH_DEPTH = 1;
    localparam int unsigned PKT_W       = 143;
    localparam int unsigned RES_W       = 128;
    localparam int unsigned RT_W        = 7;
    localparam int unsigned LAT_W       = 3;
    localparam int unsigned UNIT_W      = 4;
    localparam int unsigned STAT_W      = 32;

    // Packet field positions (index 0 is the most significant bit)
    localparam int unsigned RES_MSB = 0;
    localparam int unsigned RES_LSB = 127;
    localparam int unsigned RT_LO   = 128;
    localparam int unsigned RT_HI   = 134;
    localparam int unsigned WE_BIT  = 135;
    localparam int unsigned LAT_LO  = 136;
    localparam int unsigned LAT_HI  = 138;
    localparam int unsigned UNIT_LO = 139;
    localparam int unsigned UNIT_HI = 142;

    // Execution-unit latencies as seen by this pipe
    localparam int unsigned LAT_PERMUTE = 4;
    localparam int unsigned LAT_LSTORE  = 6;
    localparam int unsigned LAT_BRANCH  = 1;

    typedef logic [0:PKT_W-1] pkt_t;

    typedef enum logic [0:UNIT_W-1] {
        UNIT_NONE    = 4'd0,
        UNIT_PERMUTE = 4'd1,
        UNIT_LSTORE  = 4'd2,
        UNIT_BRANCH  = 4'd3
    } unit_e;

    // Latency 0 is not a legal unit latency; treat it as "ready only at retire".
    function automatic logic [0:LAT_W-1] eff_latency(input logic [0:LAT_W-1] lat);
        return (lat == '0) ? LAT_W'(DEPTH) : lat;
    endfunction

    // Add that sticks at all-ones instead of wrapping.
    function automatic logic [0:STAT_W-1] sat_add(input logic [0:STAT_W-1] a,
                                                  input logic [0:STAT_W-1] b);
        logic [0:STAT_W] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[0] ? '1 : sum[1:STAT_W];
    endfunction

endpackage

// File: rtl/odd_result_pipe_if.sv
// Result-pipe bus: producer input, forwarding taps, register-file write port.
// Statistic outputs exist only when ODD_RESULT_PIPE_STATS_EN is defined.
interface odd_result_pipe_if;
    import odd_result_pipe_pkg::*;

    logic                 in_valid;
    pkt_t                 in_packet;
    logic                 flush;
    pkt_t                 fw_op_st [1:DEPTH];
    logic [1:DEPTH]       fw_ready;
    logic                 rf_wrt_en;
    logic [0:RT_W-1]      rf_wrt_addr;
    logic [0:RES_W-1]     rf_wrt_data;
`ifdef ODD_RESULT_PIPE_STATS_EN
    logic [0:STAT_W-1]    stat_retired;
    logic [0:STAT_W-1]    stat_flushed;
`endif

    modport master (
        output in_valid, in_packet, flush,
        input  fw_op_st, fw_ready, rf_wrt_en, rf_wrt_addr, rf_wrt_data
`ifdef ODD_RESULT_PIPE_STATS_EN
      , input  stat_retired, stat_flushed
`endif
    );

    modport slave (
        input  in_valid, in_packet, flush,
        output fw_op_st, fw_ready, rf_wrt_en, rf_wrt_addr, rf_wrt_data
`ifdef ODD_RESULT_PIPE_STATS_EN
      , output stat_retired, stat_flushed
`endif
    );

endinterface

// File: rtl/odd_result_stage.sv
// One result-pipe stage: packet register with async clear and a kill that
// drops only the write-enable bit, leaving data intact for observation.
module odd_result_stage
    import odd_result_pipe_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  pkt_t i_d,
    input  logic i_kill,
    output pkt_t o_q
);

    pkt_t r_q;

    // Capture the upstream packet; a kill clears its write enable
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_q <= '0;
        end else begin
            r_q         <= i_d;
            r_q[WE_BIT] <= i_d[WE_BIT] & ~i_kill;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/odd_result_pipe.sv
// Odd-pipe result pipeline: DEPTH-stage shift register with forwarding taps,
// branch-flush kill of the youngest stages and retire at the last stage.
// Define ODD_RESULT_PIPE_STATS_EN to add retire/flush statistic counters.
module odd_result_pipe
    import odd_result_pipe_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    odd_result_pipe_if.slave   bus
);

    pkt_t           w_stage_in [1:DEPTH];
    pkt_t           w_stage    [1:DEPTH];
    logic [1:DEPTH] w_fw_ready;

    // A flush drops the incoming packet outright
    assign w_stage_in[1] = (bus.in_valid && !bus.flush) ? bus.in_packet : '0;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        localparam bit KILLABLE = (k >= 2) && (k <= FLUSH_DEPTH + 1);

        if (k > 1) begin : g_link
            assign w_stage_in[k] = w_stage[k-1];
        end

        odd_result_stage u_stage (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_d     (w_stage_in[k]),
            .i_kill  (bus.flush && KILLABLE),
            .o_q     (w_stage[k])
        );

        assign bus.fw_op_st[k] = w_stage[k];
    end

    // A stage may forward once the producing unit's latency has elapsed
    always_comb begin
        w_fw_ready = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_fw_ready[k] = w_stage[k][WE_BIT] &&
                            (LAT_W'(k) >= eff_latency(w_stage[k][LAT_LO:LAT_HI]));
        end
    end

    assign bus.fw_ready    = w_fw_ready;
    assign bus.rf_wrt_en   = w_stage[DEPTH][WE_BIT];
    assign bus.rf_wrt_addr = w_stage[DEPTH][WE_BIT] ? w_stage[DEPTH][RT_LO:RT_HI]     : '0;
    assign bus.rf_wrt_data = w_stage[DEPTH][WE_BIT] ? w_stage[DEPTH][RES_MSB:RES_LSB] : '0;

`ifdef ODD_RESULT_PIPE_STATS_EN
    logic [0:STAT_W-1] r_stat_retired;
    logic [0:STAT_W-1] r_stat_flushed;
    logic [0:STAT_W-1] w_kill_cnt;

    // Number of live packets a flush kills this edge
    always_comb begin
        w_kill_cnt = '0;
        if (bus.flush) begin
            for (int k = 1; k <= FLUSH_DEPTH; k++) begin
                if (w_stage[k][WE_BIT]) begin
                    w_kill_cnt = w_kill_cnt + STAT_W'(1);
                end
            end
        end
    end

    // Saturating retire and kill counters
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_stat_retired <= '0;
            r_stat_flushed <= '0;
        end else begin
            r_stat_retired <= sat_add(r_stat_retired, STAT_W'(w_stage[DEPTH][WE_BIT]));
            r_stat_flushed <= sat_add(r_stat_flushed, w_kill_cnt);
        end
    end

    assign bus.stat_retired = r_stat_retired;
    assign bus.stat_flushed = r_stat_flushed;
`endif

endmodule

// File: tb/tb_odd_result_pipe.sv
// Scoreboard bench for odd_result_pipe: an age-list reference model predicts
// taps, ready flags and register-file writes; a negedge monitor compares.
module tb_odd_result_pipe;
    import odd_result_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    odd_result_pipe_if bus ();

    odd_result_pipe dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    typedef struct { pkt_t pkt; int age; bit killed; } flight_t;
    typedef struct { logic [0:6] addr; logic [0:127] data; int cyc; } wr_t;

    flight_t model [$];
    wr_t     exp_wr [$];
    int      ec = 0;
    int      n_checks = 0;
    int      n_fail = 0;
    logic [31:0] exp_retired = '0;
    logic [31:0] exp_flushed = '0;

    function automatic void chk(string name, logic [142:0] act, logic [142:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ec);
        end
    endfunction

    function automatic pkt_t mk(logic [0:127] res, logic [0:6] rt, bit we,
                                logic [0:2] lat, logic [0:3] unit);
        pkt_t p;
        p = '0;
        p[RES_MSB:RES_LSB] = res;
        p[RT_LO:RT_HI]     = rt;
        p[WE_BIT]          = we;
        p[LAT_LO:LAT_HI]   = lat;
        p[UNIT_LO:UNIT_HI] = unit;
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        return mk({$urandom(), $urandom(), $urandom(), $urandom()},
                  7'($urandom_range(0, 127)), ($urandom_range(0, 7) != 0),
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    endfunction

    function automatic logic [31:0] inc_sat(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Reference model: each live packet carries its age (1 = youngest stage)
    function automatic void model_edge(bit v, pkt_t p, bit f);
        ec++;
        if (!rst_n) begin
            model.delete();
            exp_wr.delete();
            exp_retired = '0;
            exp_flushed = '0;
            return;
        end
        if (model.size() > 0 && model[0].age == int'(DEPTH) &&
            model[0].pkt[WE_BIT] && !model[0].killed)
            exp_retired = inc_sat(exp_retired);
        if (f) begin
            foreach (model[i]) begin
                if (model[i].age >= 1 && model[i].age <= int'(FLUSH_DEPTH)) begin
                    if (model[i].pkt[WE_BIT] && !model[i].killed)
                        exp_flushed = inc_sat(exp_flushed);
                    model[i].killed = 1'b1;
                end
            end
        end
        foreach (model[i]) model[i].age = model[i].age + 1;
        while (model.size() > 0 && model[0].age > int'(DEPTH)) void'(model.pop_front());
        if (v && !f) model.push_back('{p, 1, 1'b0});
        if (model.size() > 0 && model[0].age == int'(DEPTH) &&
            model[0].pkt[WE_BIT] && !model[0].killed)
            exp_wr.push_back('{model[0].pkt[RT_LO:RT_HI], model[0].pkt[RES_MSB:RES_LSB], ec});
    endfunction

    function automatic pkt_t exp_tap(int k);
        pkt_t p;
        p = '0;
        foreach (model[i]) begin
            if (model[i].age == k) begin
                p = model[i].pkt;
                if (model[i].killed) p[WE_BIT] = 1'b0;
            end
        end
        return p;
    endfunction

    function automatic bit exp_ready(int k);
        pkt_t p;
        int   l;
        p = exp_tap(k);
        l = int'(p[LAT_LO:LAT_HI]);
        if (l == 0) l = int'(DEPTH);
        return p[WE_BIT] && (k >= l);
    endfunction

    task automatic step(bit v, pkt_t p, bit f);
        bus.in_valid  = v;
        bus.in_packet = p;
        bus.flush     = f;
        @(posedge clk);
        #1;
        model_edge(v, p, f);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    // Monitor: compare DUT against model away from the active edge
    always @(negedge clk) begin
        logic [1:7] er;
        bit         exp_en;
        wr_t        w;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            chk($sformatf("fw_op_st_%0d", k), 143'(bus.fw_op_st[k]), 143'(exp_tap(k)));
            er[k] = exp_ready(k);
        end
        chk("fw_ready", 143'(bus.fw_ready), 143'(er));
        exp_en = (exp_wr.size() > 0) && (exp_wr[0].cyc == ec);
        chk("rf_wrt_en", 143'(bus.rf_wrt_en), 143'(exp_en));
        if (exp_en) begin
            w = exp_wr.pop_front();
            chk("rf_wrt_addr", 143'(bus.rf_wrt_addr), 143'(w.addr));
            chk("rf_wrt_data", 143'(bus.rf_wrt_data), 143'(w.data));
        end else begin
            chk("rf_idle_addr", 143'(bus.rf_wrt_addr), 143'(0));
            chk("rf_idle_data", 143'(bus.rf_wrt_data), 143'(0));
        end
`ifdef ODD_RESULT_PIPE_STATS_EN
        chk("stat_retired", 143'(bus.stat_retired), 143'(exp_retired));
        chk("stat_flushed", 143'(bus.stat_flushed), 143'(exp_flushed));
`endif
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", ec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        pkt_t pa;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_packet = '0;
        bus.flush     = 1'b0;
        #2;
        chk("reset_rf_wrt_en", 143'(bus.rf_wrt_en), 143'(0));
        chk("reset_fw_ready", 143'(bus.fw_ready), 143'(0));
        chk("reset_stage7", 143'(bus.fw_op_st[7]), 143'(0));
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Single permute result, latency 4
        step(1'b1, mk(128'd40, 7'd3, 1'b1, 3'(LAT_PERMUTE), UNIT_PERMUTE), 1'b0);
        idle(9);

        // Back-to-back writes
        for (int i = 1; i <= 3; i++)
            step(1'b1, mk(128'(i * 100), 7'(i), 1'b1, 3'(LAT_LSTORE), UNIT_LSTORE), 1'b0);
        idle(9);

        // Flush kills the stage-1 packet and drops the incoming one
        step(1'b1, mk(128'h5A, 7'd5, 1'b1, 3'(LAT_BRANCH), UNIT_BRANCH), 1'b0);
        step(1'b1, mk(128'h6B, 7'd6, 1'b1, 3'(LAT_BRANCH), UNIT_BRANCH), 1'b1);
        idle(9);
`ifdef ODD_RESULT_PIPE_STATS_EN
        chk("flush_stat_flushed", 143'(bus.stat_flushed), 143'(1));
`endif

        // Older packet survives a later flush
        step(1'b1, mk(128'h77, 7'd9, 1'b1, 3'd2, UNIT_PERMUTE), 1'b0);
        idle(3);
        step(1'b0, '0, 1'b1);
        idle(6);

        // Edge fields: latency 0 and write-enable clear
        step(1'b1, mk(128'h1234, 7'd11, 1'b1, 3'd0, UNIT_NONE), 1'b0);
        step(1'b1, mk(128'h9999, 7'd12, 1'b0, 3'd1, UNIT_BRANCH), 1'b0);
        idle(9);

        // Async reset with three packets in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(128'(i + 7), 7'(20 + i), 1'b1, 3'd1, UNIT_BRANCH), 1'b0);
        idle(2);
        #1;
        rst_n = 1'b0;
        model.delete();
        exp_wr.delete();
        exp_retired = '0;
        exp_flushed = '0;
        #1;
        chk("async_rst_fw_ready", 143'(bus.fw_ready), 143'(0));
        chk("async_rst_rf_wrt_en", 143'(bus.rf_wrt_en), 143'(0));
        chk("async_rst_stage1", 143'(bus.fw_op_st[1]), 143'(0));
        chk("async_rst_stage3", 143'(bus.fw_op_st[3]), 143'(0));
        idle(2);
        rst_n = 1'b1;
        idle(9);

`ifdef ODD_RESULT_PIPE_STATS_EN
        // Retire counter sticks at all-ones
        force dut.r_stat_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_stat_retired;
        exp_retired = 32'hFFFF_FFFF;
        step(1'b1, mk(128'd1, 7'd1, 1'b1, 3'd1, UNIT_BRANCH), 1'b0);
        idle(9);
        chk("stat_retired_sat", 143'(bus.stat_retired), 143'(32'hFFFF_FFFF));
`endif

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            pa = rand_pkt();
            step(($urandom_range(0, 3) != 0), pa, ($urandom_range(0, 7) == 0));
        end
        idle(10);
        chk("writes_drained", 143'(exp_wr.size()), 143'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
